sram_like_arbiter: RTL and testbench

- Merges the CPU's instruction and data SRAM-like request ports into one downstream SRAM-like master port, e.g. toward a shared cache/AXI bridge.
- Arbitrates between the two requesters and holds each grant until the address handshake completes.
- Records the source of every accepted request in an in-order ID queue.
- Routes each downstream data_ok/rdata back to the source that issued it.

---
 rtl/sram_like_arbiter_pkg.sv | 14 +
 rtl/sram_like_arbiter_arb_id_fifo.sv | 50 +++++
 rtl/sram_like_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared source IDs, grant FSM states and instruction defaults
package sram_like_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [2:0] INST_SIZE = 3'd2;

endpackage

// File: rtl/sram_like_arbiter_arb_id_fifo.sv
// rtl/sram_like_arbiter_arb_id_fifo.sv - in-order queue of 1-bit source IDs for outstanding requests
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             push_src_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_src_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push_i && !pop_i) count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - inst/data SRAM-like port merger; SRAM_ARB_RR_EN selects round-robin IDLE arbitration
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = $clog2(OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_cache,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_cache,
  output logic        m_wr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        err_spurious
);

  state_e           state_q, state_d;
  logic             hold_src_q, hold_src_d;
  logic             err_q;
  logic             grant, src_req, push, pop;
  logic             fifo_head, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
`ifdef SRAM_ARB_RR_EN
  logic             last_grant_q;
`endif

  always_comb begin
    state_d    = state_q;
    hold_src_d = hold_src_q;
    grant      = SRC_INST;
    if (state_q == ST_HOLD) begin
      grant = hold_src_q;
    end else begin
`ifdef SRAM_ARB_RR_EN
      if (inst_req && data_req) grant = ~last_grant_q;
      else grant = data_req ? SRC_DATA : SRC_INST;
`else
      grant = data_req ? SRC_DATA : SRC_INST;
`endif
    end
    // In IDLE src_req equals inst_req|data_req; in HOLD it suppresses a dropped source.
    src_req = (grant == SRC_DATA) ? data_req : inst_req;
    m_req   = src_req & ~fifo_full;
    if (state_q == ST_IDLE) begin
      if (m_req && !m_addr_ok) begin
        state_d    = ST_HOLD;
        hold_src_d = grant;
      end
    end else begin
      if (!src_req || m_addr_ok) state_d = ST_IDLE;
    end
  end

  assign push = m_req & m_addr_ok;
  assign pop  = m_data_ok & ~fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      hold_src_q <= SRC_INST;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_src_q <= hold_src_d;
      if (m_data_ok && (fifo_count == '0)) err_q <= 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_grant_q <= SRC_INST;
    else if (push) last_grant_q <= grant;
  end
`endif

  arb_id_fifo #(.DEPTH(OUTSTANDING), .CNT_W(CNT_W)) u_id_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push),
    .push_src_i (grant),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

  assign m_cache = (grant == SRC_DATA) ? data_cache : inst_cache;
  assign m_wr    = (grant == SRC_DATA) ? data_wr    : 1'b0;
  assign m_wstrb = (grant == SRC_DATA) ? data_wstrb : 4'd0;
  assign m_addr  = (grant == SRC_DATA) ? data_addr  : inst_addr;
  assign m_size  = (grant == SRC_DATA) ? data_size  : INST_SIZE;
  assign m_wdata = (grant == SRC_DATA) ? data_wdata : 32'd0;

  assign inst_addr_ok = push & (grant == SRC_INST);
  assign data_addr_ok = push & (grant == SRC_DATA);
  assign inst_data_ok = pop & (fifo_head == SRC_INST);
  assign data_data_ok = pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - randomized and directed self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cache, data_req, data_cache, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, m_rdata;
  logic [3:0]  data_wstrb;
  logic [2:0]  data_size;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_cache, m_wr, err_spurious;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_size;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_cache(m_cache), .m_wr(m_wr), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .err_spurious(err_spurious)
  );

  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok);
    inst_req = ir; data_req = dr; m_addr_ok = aok; m_data_ok = dok;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(0, 0, 0, 0);
    resetn = 1'b0;
    #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      failures++; $display("FAIL reset_oks got=%b exp=0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_spurious); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_priority();
    logic [2:0] exp_src;
    do_reset();
`ifdef SRAM_ARB_RR_EN
    exp_src = 3'b101;
`else
    exp_src = 3'b111;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0);
      #1;
      checks++; if (data_addr_ok !== exp_src[i] || inst_addr_ok !== !exp_src[i]) begin failures++;
        $display("FAIL prio_grant%0d got inst=%b data=%b exp data=%b", i, inst_addr_ok, data_addr_ok, exp_src[i]); end
      checks++; if (m_addr !== (exp_src[i] ? data_addr : inst_addr)) begin failures++;
        $display("FAIL prio_addr%0d got=%h", i, m_addr); end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      drive(1, c >= 2, c == 4, 0);
      #1;
      checks++; if (m_addr !== inst_addr || m_size !== 3'd2 || m_wr !== 1'b0) begin failures++;
        $display("FAIL hold_addr_c%0d got=%h size=%0d wr=%b exp=%h", c, m_addr, m_size, m_wr, inst_addr); end
      checks++; if (inst_addr_ok !== (c == 4) || data_addr_ok !== 1'b0) begin failures++;
        $display("FAIL hold_aok_c%0d got inst=%b data=%b", c, inst_addr_ok, data_addr_ok); end
      @(negedge clk);
    end
    drive(0, 1, 1, 0);
    #1;
    checks++; if (data_addr_ok !== 1'b1 || m_addr !== data_addr || m_wdata !== data_wdata) begin failures++;
      $display("FAIL hold_next_data got aok=%b addr=%h", data_addr_ok, m_addr); end
    @(negedge clk);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0);
      #1;
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_fill%0d got=%b exp=1", i, inst_addr_ok); end
      @(negedge clk);
    end
    drive(1, 0, 1, 1);
    #1;
    checks++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++;
      $display("FAIL full_block got m_req=%b aok=%b exp 0", m_req, inst_addr_ok); end
    checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL full_pop got=%b exp=1", inst_data_ok); end
    @(negedge clk);
    drive(1, 0, 1, 0);
    #1;
    checks++; if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin failures++;
      $display("FAIL full_unblock got m_req=%b aok=%b exp 1", m_req, inst_addr_ok); end
    @(negedge clk);
  endtask

  task automatic test_routing();
    logic [2:0] src;
    logic [31:0] rd [3];
    src = 3'b010;
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(!src[i], src[i], 1, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      m_rdata = rd[i];
      #1;
      checks++; if (inst_data_ok !== !src[i] || data_data_ok !== src[i]) begin failures++;
        $display("FAIL route%0d got inst=%b data=%b exp data=%b", i, inst_data_ok, data_data_ok, src[i]); end
      checks++; if ((src[i] ? data_rdata : inst_rdata) !== rd[i]) begin failures++;
        $display("FAIL route_rdata%0d got=%h exp=%h", i, src[i] ? data_rdata : inst_rdata, rd[i]); end
      @(negedge clk);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_spurious_reset();
    do_reset();
    drive(0, 0, 0, 1);
    #1;
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin failures++;
      $display("FAIL spur_pulse got inst=%b data=%b exp 0", inst_data_ok, data_data_ok); end
    @(negedge clk);
    drive(1, 0, 1, 0);
    #1;
    checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL spur_set got=%b exp=1", err_spurious); end
    @(negedge clk);
    drive(0, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL spur_held got=%b exp=1", err_spurious); end
    #1;
    resetn = 1'b0;
    #1;
    checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL async_reset_err got=%b exp=0", err_spurious); end
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0, 0, 1);
    #1;
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin failures++;
      $display("FAIL post_reset_discard got inst=%b data=%b exp 0", inst_data_ok, data_data_ok); end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL post_reset_spur got=%b exp=1", err_spurious); end
  endtask

  task automatic test_random();
    int q[$];
    int lock, last, g, exp_req, exp_full;
    logic exp_err, ir, dr, aok, dok;
    do_reset();
    lock = -1; last = 0; exp_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      aok = $urandom_range(0, 1);
      dok = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      drive(ir, dr, aok, dok);
      inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom; m_rdata = $urandom;
      data_wr = $urandom_range(0, 1); data_wstrb = 4'($urandom); data_size = 3'($urandom);
      inst_cache = $urandom_range(0, 1); data_cache = $urandom_range(0, 1);
      if (lock >= 0) g = lock;
`ifdef SRAM_ARB_RR_EN
      else if (ir && dr) g = 1 - last;
`endif
      else g = dr ? 1 : 0;
      exp_full = (q.size() == 4);
      exp_req = (g == 1 ? dr : ir) && !exp_full;
      #1;
      checks++; if (m_req !== 1'(exp_req)) begin failures++; $display("FAIL rnd_m_req n=%0d got=%b exp=%0d", n, m_req, exp_req); end
      checks++; if (m_addr !== (g == 1 ? data_addr : inst_addr) || m_wr !== (g == 1 ? data_wr : 1'b0)
                    || m_size !== (g == 1 ? data_size : 3'd2) || m_cache !== (g == 1 ? data_cache : inst_cache)) begin
        failures++; $display("FAIL rnd_fields n=%0d got addr=%h exp src=%0d", n, m_addr, g); end
      checks++; if (inst_addr_ok !== 1'(exp_req && aok && g == 0) || data_addr_ok !== 1'(exp_req && aok && g == 1)) begin
        failures++; $display("FAIL rnd_addr_ok n=%0d got inst=%b data=%b exp src=%0d", n, inst_addr_ok, data_addr_ok, g); end
      checks++; if (inst_data_ok !== 1'(dok && q.size() > 0 && q[0] == 0) || data_data_ok !== 1'(dok && q.size() > 0 && q[0] == 1)) begin
        failures++; $display("FAIL rnd_data_ok n=%0d got inst=%b data=%b", n, inst_data_ok, data_data_ok); end
      checks++; if (err_spurious !== exp_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err_spurious, exp_err); end
      if (dok) begin
        if (q.size() > 0) void'(q.pop_front());
        else exp_err = 1'b1;
      end
      if (exp_req && aok) begin q.push_back(g); last = g; end
      if (lock < 0) begin
        if (exp_req && !aok) lock = g;
      end else if (!(g == 1 ? dr : ir) || aok) lock = -1;
      @(negedge clk);
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    resetn = 1'b1;
    drive(0, 0, 0, 0);
    inst_cache = 1'b1; data_cache = 1'b0; data_wr = 1'b1; data_wstrb = 4'hF;
    inst_addr = 32'h1000_0040; data_addr = 32'h2000_0080; data_size = 3'd2;
    data_wdata = 32'hCAFE_F00D; m_rdata = 32'h0;
    test_reset();
    test_priority();
    test_hold();
    test_full();
    test_routing();
    test_random();
    test_spurious_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
